zbus_io_sync: RTL

- Front-end stage between the raw Z80 bus pins and the CPLD register file (rst/int register, w5300 control, sl811 control, sl811 address/data, w5300 ROM-window path).
- Brings the asynchronous Z80 strobes into the `clk` domain and filters them.
- Decodes the port or memory target and latches address and write data.
- Emits single-cycle start/end events that the register and bus-bridge logic consume.

---
 rtl/zbus_pkg.sv | 33 +++
 rtl/zbus_io_sync_filt.sv | 25 ++
 rtl/zbus_io_sync.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/zbus_pkg.sv
// zbus_pkg: shared port constants, sel indices, FSM encoding and IO decode for the Z80 bus front-end
package zbus_pkg;
  localparam logic [15:0] PORT_RSTINT  = 16'h83AB;
  localparam logic [15:0] PORT_W5300   = 16'h82AB;
  localparam logic [15:0] PORT_SL_CTL  = 16'h81AB;
  localparam logic [15:0] PORT_SL_ADDR = 16'h80AB;
  localparam logic [15:0] SL_DATA_MASK = 16'h80FF;
  localparam int SEL_RSTINT  = 0;
  localparam int SEL_W5300   = 1;
  localparam int SEL_SL_CTL  = 2;
  localparam int SEL_SL_ADDR = 3;
  localparam int SEL_SL_DATA = 4;
  localparam int SEL_MEM     = 5;
  typedef enum logic [2:0] {
    ST_WAIT_REL,
    ST_IDLE,
    ST_QUAL,
    ST_ACTIVE,
    ST_REL
  } state_e;
  function automatic logic [4:0] io_decode(input logic [15:0] a, input logic [7:0] lb);
    logic [4:0] r;
    logic m;
    m = a[7:0] == lb;
    r = '0;
    r[SEL_RSTINT]  = m && a[15:8] == PORT_RSTINT[15:8];
    r[SEL_W5300]   = m && a[15:8] == PORT_W5300[15:8];
    r[SEL_SL_CTL]  = m && a[15:8] == PORT_SL_CTL[15:8];
    r[SEL_SL_ADDR] = m && a[15:8] == PORT_SL_ADDR[15:8];
    r[SEL_SL_DATA] = m && (a[15:8] & SL_DATA_MASK[15:8]) == 8'h00;
    return r;
  endfunction
endpackage

// File: rtl/zbus_io_sync_filt.sv
// zbus_filt: 2-flop synchroniser with a FILT-sample agreement counter for one Z80 strobe
module zbus_filt #(
  parameter int FILT = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic pin_n,
  output logic sync_n,
  output logic stable
);
  localparam logic [1:0] CMAX = 2'(FILT - 1);
  logic s1_q, s2_q;
  logic [1:0] cnt_q, cnt_d;
  always_ff @(posedge clk) begin
    s1_q <= pin_n;
    s2_q <= s1_q;
  end
  always_comb cnt_d = (s1_q != s2_q) ? 2'd0 : (cnt_q == CMAX) ? cnt_q : cnt_q + 2'd1;
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign sync_n = s2_q;
  assign stable = cnt_q == CMAX;
endmodule

// File: rtl/zbus_io_sync.sv
// zbus_io_sync: synchronises and filters Z80 strobes, decodes the target, latches address/data
// and emits single-cycle start/end/error events for the register and bridge logic.
module zbus_io_sync
  import zbus_pkg::*;
#(
  parameter logic [7:0] LOW_BYTE = 8'hAB,
  parameter int         FILT     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] za,
  input  logic [7:0]  zd_in,
  input  logic        ziorq_n,
  input  logic        zmreq_n,
  input  logic        zrd_n,
  input  logic        zwr_n,
  input  logic        zcsrom_n,
  input  logic        mem_ena,
  output logic        ziorqge,
  output logic [5:0]  sel,
  output logic [15:0] addr_lat,
  output logic [7:0]  wdata,
  output logic        wr_stb,
  output logic        rd_stb,
  output logic        rd_end,
  output logic        busy,
  output logic        err_stb
);
  logic iorq_s, mreq_s, rd_s, wr_s, csrom_s;
  logic [4:0] stb;
  zbus_filt #(.FILT(FILT)) u_iorq  (.clk(clk), .rst(rst), .pin_n(ziorq_n),  .sync_n(iorq_s),  .stable(stb[0]));
  zbus_filt #(.FILT(FILT)) u_mreq  (.clk(clk), .rst(rst), .pin_n(zmreq_n),  .sync_n(mreq_s),  .stable(stb[1]));
  zbus_filt #(.FILT(FILT)) u_rd    (.clk(clk), .rst(rst), .pin_n(zrd_n),    .sync_n(rd_s),    .stable(stb[2]));
  zbus_filt #(.FILT(FILT)) u_wr    (.clk(clk), .rst(rst), .pin_n(zwr_n),    .sync_n(wr_s),    .stable(stb[3]));
  zbus_filt #(.FILT(FILT)) u_csrom (.clk(clk), .rst(rst), .pin_n(zcsrom_n), .sync_n(csrom_s), .stable(stb[4]));
  // strobe type vector: [0] io_rd, [1] io_wr, [2] mem_rd, [3] mem_wr
  logic [3:0] v, typ_q, typ_d, cur;
  logic st_all, multi, is_wr, is_mem, hit;
  logic [4:0] iod;
  assign v = {!mreq_s & !csrom_s & !wr_s & mem_ena, !mreq_s & !csrom_s & !rd_s & mem_ena,
              !iorq_s & !wr_s, !iorq_s & !rd_s};
  assign st_all = &stb;
  assign multi = |(v & (v - 4'd1));
  assign is_wr = typ_q[1] | typ_q[3];
  assign is_mem = typ_q[2] | typ_q[3];
  assign iod = io_decode(za, LOW_BYTE);
  assign hit = is_mem | (|iod);
  assign ziorqge = !ziorq_n & (|io_decode(za, LOW_BYTE));
  state_e state_q, state_d;
  logic acc_q, acc_d, rdc_q, rdc_d, busy_q, busy_d;
  logic wr_q, wr_d, rd_q, rd_d, end_q, end_d, err_q, err_d;
  logic [5:0] sel_q, sel_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  always_comb begin
    state_d = state_q;
    typ_d = typ_q;
    acc_d = 1'b0;
    rdc_d = rdc_q;
    busy_d = busy_q;
    sel_d = sel_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    wr_d = 1'b0;
    rd_d = 1'b0;
    end_d = 1'b0;
    err_d = 1'b0;
    cur = (state_q == ST_IDLE) ? v : typ_q;
    case (state_q)
      ST_WAIT_REL, ST_REL: if (v == '0 && st_all) begin
        state_d = ST_IDLE;
        end_d = busy_q & rdc_q;
        busy_d = 1'b0;
      end
      // IDLE takes the first sample; QUAL waits for every strobe to agree for FILT samples
      ST_IDLE, ST_QUAL: begin
        typ_d = cur;
        if (v == '0 || v != cur) state_d = ST_IDLE;
        else if (!st_all) state_d = ST_QUAL;
        else if (multi) begin
          err_d = 1'b1;
          state_d = ST_REL;
        end else begin
          state_d = ST_ACTIVE;
          acc_d = 1'b1;
        end
      end
      ST_ACTIVE: if (acc_q) begin
        if (hit) begin
          sel_d = {is_mem, is_mem ? 5'b0 : iod};
          addr_d = za;
          wdata_d = is_wr ? zd_in : wdata_q;
          wr_d = is_wr;
          rd_d = !is_wr;
          rdc_d = !is_wr;
          busy_d = 1'b1;
        end else state_d = ST_REL;
      end else if (v == '0) state_d = ST_REL;
      else if (v != typ_q) begin
        end_d = busy_q & rdc_q;
        busy_d = 1'b0;
        typ_d = v;
        state_d = ST_QUAL;
      end
      default: state_d = ST_WAIT_REL;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_WAIT_REL;
      typ_q <= '0;
      acc_q <= 1'b0;
      rdc_q <= 1'b0;
      busy_q <= 1'b0;
      sel_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      wr_q <= 1'b0;
      rd_q <= 1'b0;
      end_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      typ_q <= typ_d;
      acc_q <= acc_d;
      rdc_q <= rdc_d;
      busy_q <= busy_d;
      sel_q <= sel_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      end_q <= end_d;
      err_q <= err_d;
    end
  end
  assign sel = sel_q;
  assign addr_lat = addr_q;
  assign wdata = wdata_q;
  assign wr_stb = wr_q;
  assign rd_stb = rd_q;
  assign rd_end = end_q;
  assign busy = busy_q;
  assign err_stb = err_q;
endmodule
